window_line_ctrl: RTL and testbench

- Buffers the incoming raster pixel stream into four circular line buffers and sequences 3x3 pixel windows, one per cycle, into the convolution pipeline as a 72-bit window plus valid.
- Sits directly upstream of the convolution module.
- Raises a one-cycle interrupt each time a line buffer is released, so the host DMA can push the next line.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/line_buffer.sv | 47 ++++
 rtl/window_line_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_window_line_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the window line controller and the convolution path:
// pixel/window widths, default line width, read-FSM states and window indexing.
package conv_pkg;

  localparam int PIX_W         = 8;
  localparam int WIN_ROWS      = 3;
  localparam int WIN_COLS      = 3;
  localparam int ROW_W         = WIN_COLS * PIX_W;   // one window row, 24 bits
  localparam int WIN_W         = WIN_ROWS * ROW_W;   // full 3x3 window, 72 bits
  localparam int IMG_WIDTH_DEF = 512;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LINE = 2'd1,
    RELEASE = 2'd2
  } rd_state_e;

  // Bit offset of window byte (row, col); row 0 is the oldest line, col 0 leftmost.
  function automatic int win_byte_lsb(input int row, input int col);
    return (WIN_COLS * row + col) * PIX_W;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One raster line of storage: single write port and a registered read of three
// adjacent pixels (rd_ptr, rd_ptr+1, rd_ptr+2) packed col 0 in the low byte.
// Contents are never cleared; only the read data register is meaningful after rd_en.
module line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int AW        = $clog2(IMG_WIDTH)
) (
  input  logic             i_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_ptr,
  output logic [ROW_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];

  // Pixel write into the line storage
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_COLS; gi++) begin : g_col
      logic [AW-1:0]    col_addr;
      logic [PIX_W-1:0] col_reg;

      assign col_addr = rd_ptr + AW'(gi);

      // Registered read of one window column
      always_ff @(posedge i_clk) begin
        if (rd_en) begin
          col_reg <= mem[col_addr];
        end
      end

      assign rd_data[gi*PIX_W +: PIX_W] = col_reg;
    end
  endgenerate

endmodule

// File: rtl/window_line_ctrl.sv
// Window line controller: writes the raster stream round-robin into four line
// buffers and, once three complete lines are held, issues one 3x3 window per
// cycle across the band, then releases the oldest line and pulses o_intr.
// Optional feature: define LBUF_OVERFLOW_FLAG_EN to add the sticky o_overflow
// output that records any pixel offered while o_pixel_ready was low.
module window_line_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int NUM_LINES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic             o_pixel_ready,
  input  logic             i_rd_stall,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr
`ifdef LBUF_OVERFLOW_FLAG_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int NBUF = 4;
  localparam int AW   = $clog2(IMG_WIDTH);
  localparam logic [AW-1:0] LAST_COL = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] LAST_WIN = AW'(IMG_WIDTH - 3);

  generate
    if (NUM_LINES != NBUF) begin : g_bad_num_lines
      $error("window_line_ctrl: NUM_LINES must be 4");
    end
    if (IMG_WIDTH < 4 || IMG_WIDTH > 4096) begin : g_bad_img_width
      $error("window_line_ctrl: IMG_WIDTH must be within 4..4096");
    end
  endgenerate

  // Write side
  logic [AW-1:0] wr_ptr_reg;
  logic [1:0]    wr_sel_reg;
  logic [2:0]    lines_full_reg;
  logic [2:0]    lines_full_next;
  logic          pix_accept;
  logic          line_done;

  // Read side
  rd_state_e     state_reg;
  rd_state_e     state_next;
  logic [AW-1:0] rd_ptr_reg;
  logic [1:0]    rd_sel_reg;
  logic [1:0]    rd_sel_out_reg;   // rd_sel captured with the issued window
  logic          win_valid_reg;
  logic          intr_reg;
  logic          issue;
  logic          band_release;
  logic          rd_ptr_clr;

  logic [ROW_W-1:0] buf_rdata [NBUF];

  assign o_pixel_ready = (lines_full_reg != 3'd4);
  assign pix_accept    = i_pixel_data_valid && o_pixel_ready;
  assign line_done     = pix_accept && (wr_ptr_reg == LAST_COL);

  // Occupancy count: a completed line and a released band in one cycle cancel
  always_comb begin
    lines_full_next = lines_full_reg;
    case ({line_done, band_release})
      2'b10:   lines_full_next = lines_full_reg + 3'd1;
      2'b01:   lines_full_next = lines_full_reg - 3'd1;
      default: lines_full_next = lines_full_reg;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM next-state: start a band with three lines held, leave after last window
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (lines_full_reg >= 3'd3) state_next = RD_LINE;
      RD_LINE: if (!i_rd_stall && rd_ptr_reg == LAST_WIN) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read FSM outputs: window issue, band release and read-pointer clear
  always_comb begin
    issue        = 1'b0;
    band_release = 1'b0;
    rd_ptr_clr   = 1'b0;
    case (state_reg)
      IDLE:    rd_ptr_clr   = 1'b1;
      RD_LINE: issue        = !i_rd_stall;
      RELEASE: band_release = 1'b1;
      default: rd_ptr_clr   = 1'b1;
    endcase
  end

  // Pointers, occupancy and output qualifiers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg     <= '0;
      wr_sel_reg     <= '0;
      lines_full_reg <= '0;
      rd_ptr_reg     <= '0;
      rd_sel_reg     <= '0;
      rd_sel_out_reg <= '0;
      win_valid_reg  <= 1'b0;
      intr_reg       <= 1'b0;
    end else begin
      if (pix_accept) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_COL) ? '0 : wr_ptr_reg + AW'(1);
      end
      if (line_done) begin
        wr_sel_reg <= wr_sel_reg + 2'd1;
      end
      lines_full_reg <= lines_full_next;

      if (rd_ptr_clr) begin
        rd_ptr_reg <= '0;
      end else if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (band_release) begin
        rd_sel_reg <= rd_sel_reg + 2'd1;
      end
      if (issue) begin
        rd_sel_out_reg <= rd_sel_reg;
      end
      win_valid_reg <= issue;
      intr_reg      <= band_release;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBUF; gi++) begin : g_buf
      logic wr_en_buf;
      logic rd_en_buf;

      assign wr_en_buf = pix_accept && (wr_sel_reg == 2'(gi));
      // The buffer three ahead of rd_sel is the one being written; never read it
      assign rd_en_buf = issue && ((2'(gi) - rd_sel_reg) != 2'd3);

      line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .AW        (AW)
      ) u_line_buffer (
        .i_clk   (i_clk),
        .wr_en   (wr_en_buf),
        .wr_ptr  (wr_ptr_reg),
        .wr_data (i_pixel_data),
        .rd_en   (rd_en_buf),
        .rd_ptr  (rd_ptr_reg),
        .rd_data (buf_rdata[gi])
      );
    end

    for (gi = 0; gi < WIN_ROWS; gi++) begin : g_row
      logic [1:0] row_sel;

      // Window row gi comes from the buffer gi places after the oldest one
      assign row_sel = rd_sel_out_reg + 2'(gi);
      assign o_pixel_data[gi*ROW_W +: ROW_W] = win_valid_reg ? buf_rdata[row_sel] : '0;
    end
  endgenerate

  assign o_pixel_data_valid = win_valid_reg;
  assign o_intr             = intr_reg;

`ifdef LBUF_OVERFLOW_FLAG_EN
  logic overflow_reg;

  // Sticky record of any pixel offered while the write side was full
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_reg <= 1'b0;
    end else if (i_pixel_data_valid && !o_pixel_ready) begin
      overflow_reg <= 1'b1;
    end
  end

  assign o_overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_window_line_ctrl.sv
// Directed bench for window_line_ctrl at IMG_WIDTH=8, pixel = 16*line + col.
// Expected windows are queued when the completing line is written and popped
// as the DUT presents valid windows.
module tb_window_line_ctrl;
  import conv_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix = '0;
  logic        pix_valid = 1'b0;
  logic        ready;
  logic        stall = 1'b0;
  logic [71:0] win;
  logic        win_valid;
  logic        intr;
`ifdef LBUF_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int win_seen = 0;
  int intr_seen = 0;
  int ready_low_seen = 0;
  logic intr_prev = 1'b0;
  logic [71:0] exp_q[$];

  always #5 clk = ~clk;

  window_line_ctrl #(
    .IMG_WIDTH (W),
    .NUM_LINES (4)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_ready      (ready),
    .i_rd_stall         (stall),
    .o_pixel_data       (win),
    .o_pixel_data_valid (win_valid),
    .o_intr             (intr)
`ifdef LBUF_OVERFLOW_FLAG_EN
    ,
    .o_overflow         (overflow)
`endif
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int band, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int cc = 0; cc < 3; cc++) begin
        w[win_byte_lsb(r, cc) +: 8] = 8'(16 * (band + r) + col + cc);
      end
    end
    return w;
  endfunction

  task automatic push_band(input int band);
    for (int c = 0; c < W - 2; c++) exp_q.push_back(exp_win(band, c));
  endtask

  // One clock step; outputs sampled 1 time unit after the rising edge
  task automatic tick();
    logic [71:0] e;
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_valid", 72'(win_valid), 72'(0));
      check("rst_intr", 72'(intr), 72'(0));
      intr_prev = 1'b0;
    end else begin
      if (win_valid) begin
        win_seen++;
        $display("[TB] window %0d data=%h", win_seen, win);
        check("win_expected", 72'(exp_q.size() != 0), 72'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("window", win, e);
        end
      end
      if (intr) begin
        intr_seen++;
        $display("[TB] intr %0d", intr_seen);
        check("intr_width", 72'(intr_prev), 72'(0));
      end
      intr_prev = intr;
      if (!ready) ready_low_seen++;
    end
  endtask

  task automatic write_line(input int line);
    for (int c = 0; c < W; c++) begin
      pix = 8'(16 * line + c);
      pix_valid = 1'b1;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 72'(exp_q.size()), 72'(0));
    exp_q.delete();
    repeat (4) tick();
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    stall = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    intr_prev = 1'b0;
  endtask

  initial begin
    int w0, i0, r0;

    // Power-on reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_data", win, 72'(0));
    check("rst_ready", 72'(ready), 72'(1));
    rst = 1'b0;

    // Three lines: 6 windows, one interrupt, two lines left held
    w0 = win_seen; i0 = intr_seen;
    write_line(0);
    write_line(1);
    push_band(0);
    write_line(2);
    tick();
    check("lat_e1_valid", 72'(win_valid), 72'(0));
    tick();
    check("lat_e2_valid", 72'(win_valid), 72'(1));
    drain(100);
    check("a_windows", 72'(win_seen - w0), 72'(6));
    check("a_intr", 72'(intr_seen - i0), 72'(1));
    check("a_lines_full", 72'(dut.lines_full_reg), 72'(2));

    // Reset in the middle of a band, then a fresh fill
    do_reset();
    w0 = win_seen;
    write_line(0);
    write_line(1);
    push_band(0);
    write_line(2);
    tick();
    tick();
    tick();
    check("mid_band_active", 72'((win_seen - w0) >= 2), 72'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 72'(win_valid), 72'(0));
    check("mid_rst_intr", 72'(intr), 72'(0));
    check("mid_rst_data", win, 72'(0));
    rst = 1'b0;
    exp_q.delete();
    intr_prev = 1'b0;
    w0 = win_seen;
    write_line(0);
    write_line(1);
    push_band(0);
    write_line(2);
    drain(100);
    check("fresh_windows", 72'(win_seen - w0), 72'(6));

    // Six lines streamed: 4 bands, 4 interrupts, never back-pressured
    do_reset();
    w0 = win_seen; i0 = intr_seen; r0 = ready_low_seen;
    for (int l = 0; l < 6; l++) begin
      if (l >= 2) push_band(l - 2);
      write_line(l);
    end
    drain(200);
    check("b_windows", 72'(win_seen - w0), 72'(24));
    check("b_intr", 72'(intr_seen - i0), 72'(4));
    check("b_ready_low", 72'(ready_low_seen - r0), 72'(0));

    // Stalled reader: buffers fill, fifth line dropped, then two bands drain
    do_reset();
    stall = 1'b1;
    w0 = win_seen;
    for (int l = 0; l < 4; l++) write_line(l);
    check("c_ready_full", 72'(ready), 72'(0));
    check("c_no_window", 72'(win_seen - w0), 72'(0));
    write_line(4);
    check("c_lines_full", 72'(dut.lines_full_reg), 72'(4));
`ifdef LBUF_OVERFLOW_FLAG_EN
    check("c_overflow_set", 72'(overflow), 72'(1));
`endif
    push_band(0);
    push_band(1);
    stall = 1'b0;
    drain(200);
    check("c_windows", 72'(win_seen - w0), 72'(12));
    check("c_ready_again", 72'(ready), 72'(1));
`ifdef LBUF_OVERFLOW_FLAG_EN
    check("c_overflow_sticky", 72'(overflow), 72'(1));
`endif

    // Stall toggled every cycle during a band: same 6 windows, in order
    do_reset();
    stall = 1'b1;
    w0 = win_seen;
    write_line(0);
    write_line(1);
    push_band(0);
    write_line(2);
    for (int k = 0; k < 30; k++) begin
      stall = ~stall;
      tick();
    end
    stall = 1'b0;
    drain(100);
    check("d_windows", 72'(win_seen - w0), 72'(6));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
